// File: rtl/vga_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_scheduler
//  Purpose  : Time-slotted owner of the VGA plot port. Each frame starts the
//             map, character and HUD drawers in turn and forwards the active
//             drawer's plot/x/y/color. A slot ends on done or budget timeout,
//             then the scheduler idles until the frame period expires.
//  Revision : 1.0  initial release
// ============================================================================
module vga_frame_scheduler #(
  parameter int FRAME_CYCLES = 12000,
  parameter int MAP_BUDGET   = 11025,
  parameter int CHAR_BUDGET  = 256,
  parameter int HUD_BUDGET   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  slot_en,
  input  logic        clr_overrun,
  input  logic [2:0]  src_done,
  input  logic [2:0]  src_plot,
  input  logic [23:0] src_x,
  input  logic [23:0] src_y,
  input  logic [8:0]  src_color,
  output logic [2:0]  src_start,
  output logic        vgaPlot,
  output logic [7:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vgaColor,
  output logic        isDispRunning,
  output logic        frame_tick,
  output logic [2:0]  overrun
);

  // Budgets must fit in one frame and leave room for start + done cycles.
  if ((MAP_BUDGET + CHAR_BUDGET + HUD_BUDGET > FRAME_CYCLES) ||
      (MAP_BUDGET < 2) || (CHAR_BUDGET < 2) || (HUD_BUDGET < 2) ||
      (FRAME_CYCLES > 32768)) begin : g_bad_params
    $error("vga_frame_scheduler: invalid frame/budget parameters");
  end

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_MAP  = 3'd1;
  localparam logic [2:0] c_CHAR = 3'd2;
  localparam logic [2:0] c_HUD  = 3'd3;
  localparam logic [2:0] c_WAIT = 3'd4;

  localparam logic [14:0] c_FRAME_LAST = 15'(FRAME_CYCLES - 1);
  localparam logic [14:0] c_MAP_LAST   = 15'(MAP_BUDGET - 1);
  localparam logic [14:0] c_CHAR_LAST  = 15'(CHAR_BUDGET - 1);
  localparam logic [14:0] c_HUD_LAST   = 15'(HUD_BUDGET - 1);

  // First enabled slot strictly after 'cur' (IDLE means "from the top").
  function automatic logic [2:0] f_next_slot(input logic [2:0] mask, input logic [2:0] cur);
    logic [2:0] nxt;
    nxt = c_WAIT;
    if (cur == c_IDLE && mask[0])                        nxt = c_MAP;
    else if ((cur == c_IDLE || cur == c_MAP) && mask[1]) nxt = c_CHAR;
    else if (cur != c_HUD && mask[2])                    nxt = c_HUD;
    return nxt;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [2:0] st);
    logic [2:0] oh;
    oh = 3'b000;
    case (st)
      c_MAP:   oh = 3'b001;
      c_CHAR:  oh = 3'b010;
      c_HUD:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  r_mask;
  logic [14:0] r_frame_cnt;
  logic [14:0] r_slot_cnt;
  logic [2:0]  r_src_start;
  logic        r_vga_plot;
  logic [7:0]  r_vga_x;
  logic [7:0]  r_vga_y;
  logic [2:0]  r_vga_color;
  logic        r_disp;
  logic        r_tick;
  logic [2:0]  r_overrun;

  logic        w_in_slot;
  logic [14:0] w_budget_last;
  logic        w_sel_done;
  logic        w_sel_plot;
  logic [7:0]  w_sel_x;
  logic [7:0]  w_sel_y;
  logic [2:0]  w_sel_color;
  logic        w_done;
  logic        w_timeout;
  logic        w_slot_end;
  logic        w_frame_last;
  logic        w_frame_start;
  logic [2:0]  w_next_state;
  logic        w_enter;
  logic [2:0]  w_ovr_set;

  assign w_in_slot = (r_state == c_MAP) || (r_state == c_CHAR) || (r_state == c_HUD);

  // Select the active source's budget, done and pixel data.
  always_comb begin
    w_budget_last = 15'd0;
    w_sel_done    = 1'b0;
    w_sel_plot    = 1'b0;
    w_sel_x       = r_vga_x;
    w_sel_y       = r_vga_y;
    w_sel_color   = r_vga_color;
    case (r_state)
      c_MAP: begin
        w_budget_last = c_MAP_LAST;
        w_sel_done    = src_done[0];
        w_sel_plot    = src_plot[0];
        w_sel_x       = src_x[7:0];
        w_sel_y       = src_y[7:0];
        w_sel_color   = src_color[2:0];
      end
      c_CHAR: begin
        w_budget_last = c_CHAR_LAST;
        w_sel_done    = src_done[1];
        w_sel_plot    = src_plot[1];
        w_sel_x       = src_x[15:8];
        w_sel_y       = src_y[15:8];
        w_sel_color   = src_color[5:3];
      end
      c_HUD: begin
        w_budget_last = c_HUD_LAST;
        w_sel_done    = src_done[2];
        w_sel_plot    = src_plot[2];
        w_sel_x       = src_x[23:16];
        w_sel_y       = src_y[23:16];
        w_sel_color   = src_color[8:6];
      end
      default: ;
    endcase
  end

  // Done is ignored on the slot's start cycle; done beats a coincident timeout.
  assign w_done       = w_in_slot && w_sel_done && (r_slot_cnt != 15'd0);
  assign w_timeout    = w_in_slot && (r_slot_cnt == w_budget_last);
  assign w_slot_end   = w_done || w_timeout;
  assign w_frame_last = (r_frame_cnt == c_FRAME_LAST);
  assign w_ovr_set    = (w_timeout && !w_done) ? f_onehot(r_state) : 3'b000;

  // Next-state decision; a frame start always re-samples slot_en.
  always_comb begin
    w_next_state  = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      c_IDLE: w_frame_start = en;
      c_MAP, c_CHAR, c_HUD: begin
        if (w_slot_end) begin
          if (w_frame_last) begin
            if (en) w_frame_start = 1'b1;
            else    w_next_state  = c_IDLE;
          end else begin
            w_next_state = f_next_slot(r_mask, r_state);
          end
        end
      end
      c_WAIT: begin
        if (w_frame_last) begin
          if (en) w_frame_start = 1'b1;
          else    w_next_state  = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
    if (w_frame_start) w_next_state = f_next_slot(slot_en, c_IDLE);
  end

  assign w_enter = (w_frame_start || w_slot_end) && (f_onehot(w_next_state) != 3'b000);

  // Sequencer state, frame/slot counters and the start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_mask      <= 3'b000;
      r_frame_cnt <= 15'd0;
      r_slot_cnt  <= 15'd0;
      r_src_start <= 3'b000;
      r_tick      <= 1'b0;
      r_disp      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      if (w_frame_start) r_mask <= slot_en;
      if (w_frame_start || w_frame_last) r_frame_cnt <= 15'd0;
      else if (r_state != c_IDLE)        r_frame_cnt <= r_frame_cnt + 15'd1;
      if (w_enter)        r_slot_cnt <= 15'd0;
      else if (w_in_slot) r_slot_cnt <= r_slot_cnt + 15'd1;
      r_src_start <= w_enter ? f_onehot(w_next_state) : 3'b000;
      r_tick      <= w_frame_start;
      r_disp      <= (f_onehot(w_next_state) != 3'b000);
    end
  end

  // VGA forwarding: only the active slot's source reaches the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vga_plot  <= 1'b0;
      r_vga_x     <= 8'd0;
      r_vga_y     <= 8'd0;
      r_vga_color <= 3'd0;
    end else begin
      r_vga_plot  <= w_in_slot & w_sel_plot;
      r_vga_x     <= w_sel_x;
      r_vga_y     <= w_sel_y;
      r_vga_color <= w_sel_color;
    end
  end

  // Sticky overrun flags; a same-cycle set wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_overrun <= 3'b000;
    else        r_overrun <= (clr_overrun ? 3'b000 : r_overrun) | w_ovr_set;
  end

  assign src_start     = r_src_start;
  assign vgaPlot       = r_vga_plot;
  assign vga_x         = r_vga_x;
  assign vga_y         = r_vga_y;
  assign vgaColor      = r_vga_color;
  assign isDispRunning = r_disp;
  assign frame_tick    = r_tick;
  assign overrun       = r_overrun;

endmodule
`default_nettype wire
